// File: rtl/board_uart_printer_pkg.sv
// Shared constants for the 2048 board printer: geometry, frame length,
// ASCII bytes and the printer state encoding.
package twentyfortyeight_pkg;

  localparam int CELL_W    = 20;
  localparam int NUM_CELLS = 16;
  localparam int SCORE_W   = 21;
  localparam int DIGITS    = 7;
  localparam int FRAME_LEN = 151;

  localparam logic [7:0] ASCII_SP   = 8'h20;
  localparam logic [7:0] ASCII_DOT  = 8'h2E;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [39:0] SCORE_STR = 40'h53_43_4F_52_45; // "SCORE"

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_EMIT,
    ST_DONE
  } state_t;

  // Byte idx (0..4) of the "SCORE" label.
  function automatic logic [7:0] score_char(input logic [2:0] idx);
    logic [7:0] c;
    c = SCORE_STR[8*(4-int'(idx)) +: 8];
    return c;
  endfunction

endpackage

// File: rtl/board_uart_printer_if.sv
// Byte stream from the printer to the UART transmitter.
interface board_uart_printer_if;
  logic [7:0] char_out;
  logic       char_valid;
  logic       tx_ready;

  modport master (output char_out, output char_valid, input tx_ready);
  modport slave  (input char_out, input char_valid, output tx_ready);
endinterface

// File: rtl/board_uart_printer_bin2bcd.sv
// Sequential shift-add-3 binary to BCD converter, one bit per cycle.
// load starts a conversion; valid rises together with the final shift.
module bin2bcd_seq #(
  parameter int IN_W   = 21,
  parameter int DIGITS = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [IN_W-1:0]       bin_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  valid
);

  localparam int CNT_W = $clog2(IN_W + 1);

  logic [CNT_W-1:0]    cnt;
  logic [IN_W-1:0]     sh_bin;
  logic [4*DIGITS-1:0] sh_bcd;
  logic [4*DIGITS-1:0] adj;

  function automatic logic [4*DIGITS-1:0] add3(input logic [4*DIGITS-1:0] v);
    logic [4*DIGITS-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign adj     = add3(sh_bcd);
  assign bcd_out = sh_bcd;

  // Shift counter and completion flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      valid <= 1'b0;
    end else if (load) begin
      cnt   <= CNT_W'(IN_W);
      valid <= 1'b0;
    end else if (cnt != '0) begin
      cnt   <= cnt - 1'b1;
      valid <= (cnt == CNT_W'(1));
    end
  end

  // Datapath: adjust digits then shift the next binary MSB in.
  always_ff @(posedge clk) begin
    if (load) begin
      sh_bin <= bin_in;
      sh_bcd <= '0;
    end else if (cnt != '0) begin
      sh_bcd <= {adj[4*DIGITS-2:0], sh_bin[IN_W-1]};
      sh_bin <= {sh_bin[IN_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/board_uart_printer.sv
// Prints a snapshot of the 4x4 board and score as a 151-byte ASCII frame:
// four rows of four 8-byte fields plus CR LF, then "SCORE", score field, CR LF.
module board_uart_printer
  import twentyfortyeight_pkg::*;
#(
  parameter int CELL_W  = 20,
  parameter int SCORE_W = 21,
  parameter int DIGITS  = 7
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [NUM_CELLS*CELL_W-1:0] board,
  input  logic [SCORE_W-1:0]          score,
  board_uart_printer_if.master        tx,
  output logic                        busy,
  output logic                        done
);

  localparam logic [4:0] FIELD_SCORE = 5'd16;

  state_t                      state, state_d;
  logic [4:0]                  field, field_d;
  logic [2:0]                  byte_cnt, byte_d;
  logic [2:0]                  sfx_cnt, sfx_d;
  logic                        in_sfx, in_sfx_d;
  logic                        lz, lz_d;
  logic [4:0]                  conv_cnt, conv_d;
  logic                        snap, load;
  logic [SCORE_W-1:0]          load_val;
  logic [NUM_CELLS*CELL_W-1:0] board_q;
  logic [SCORE_W-1:0]          score_q;
  logic [4*DIGITS-1:0]         bcd;
  logic                        bcd_valid;
  logic [3:0]                  digit;
  logic [2:0]                  didx;
  logic                        is_last, last_sfx;
  logic [4:0]                  nf;
  logic [7:0]                  char_byte;
  logic                        char_vld;

  bin2bcd_seq #(.IN_W(SCORE_W), .DIGITS(DIGITS)) u_bcd (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .bin_in  (load_val),
    .bcd_out (bcd),
    .valid   (bcd_valid)
  );

  assign tx.char_out   = char_byte;
  assign tx.char_valid = char_vld;

  assign didx     = 3'(DIGITS) - byte_cnt;
  assign digit    = 4'(bcd >> (4 * didx));
  assign is_last  = (byte_cnt == 3'(DIGITS));
  assign last_sfx = (field == 5'd15) ? (sfx_cnt == 3'd6) : (sfx_cnt == 3'd1);
  assign nf       = field + 5'd1;

  // State and frame counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      field    <= '0;
      byte_cnt <= '0;
      sfx_cnt  <= '0;
      in_sfx   <= 1'b0;
      lz       <= 1'b0;
      conv_cnt <= '0;
    end else begin
      state    <= state_d;
      field    <= field_d;
      byte_cnt <= byte_d;
      sfx_cnt  <= sfx_d;
      in_sfx   <= in_sfx_d;
      lz       <= lz_d;
      conv_cnt <= conv_d;
    end
  end

  // Input snapshot taken when a frame starts.
  always_ff @(posedge clk) begin
    if (snap) begin
      board_q <= board;
      score_q <= score;
    end
  end

  // Next-state, byte selection and handshake outputs.
  always_comb begin
    state_d   = state;
    field_d   = field;
    byte_d    = byte_cnt;
    sfx_d     = sfx_cnt;
    in_sfx_d  = in_sfx;
    lz_d      = lz;
    conv_d    = conv_cnt;
    snap      = 1'b0;
    load      = 1'b0;
    load_val  = '0;
    char_vld  = 1'b0;
    char_byte = 8'h00;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          snap     = 1'b1;
          load     = 1'b1;
          load_val = SCORE_W'(board[CELL_W-1:0]);
          field_d  = '0;
          byte_d   = '0;
          sfx_d    = '0;
          in_sfx_d = 1'b0;
          lz_d     = 1'b1;
          conv_d   = '0;
          state_d  = ST_CONV;
        end
      end
      ST_CONV: begin
        busy = 1'b1;
        if (conv_cnt == 5'(SCORE_W - 1)) begin
          conv_d  = '0;
          state_d = ST_EMIT;
        end else begin
          conv_d = conv_cnt + 5'd1;
        end
      end
      ST_EMIT: begin
        busy     = 1'b1;
        char_vld = bcd_valid;
        // A zero cell ends in '.', a zero score still shows its units digit.
        if (in_sfx) begin
          if (sfx_cnt == 3'd0)      char_byte = ASCII_CR;
          else if (sfx_cnt == 3'd1) char_byte = ASCII_LF;
          else                      char_byte = score_char(sfx_cnt - 3'd2);
        end else if (byte_cnt == 3'd0) begin
          char_byte = ASCII_SP;
        end else if (lz && digit == 4'd0 && !is_last) begin
          char_byte = ASCII_SP;
        end else if (lz && digit == 4'd0 && field != FIELD_SCORE) begin
          char_byte = ASCII_DOT;
        end else begin
          char_byte = ASCII_ZERO + {4'd0, digit};
        end
        if (char_vld && tx.tx_ready) begin
          if (!in_sfx) begin
            if (byte_cnt != 3'd0 && digit != 4'd0) lz_d = 1'b0;
            if (!is_last) begin
              byte_d = byte_cnt + 3'd1;
            end else begin
              byte_d = '0;
              if (field[1:0] == 2'd3 || field == FIELD_SCORE) begin
                in_sfx_d = 1'b1;
                sfx_d    = '0;
              end else begin
                field_d  = nf;
                lz_d     = 1'b1;
                load     = 1'b1;
                load_val = SCORE_W'(board_q[CELL_W*nf[3:0] +: CELL_W]);
                state_d  = ST_CONV;
              end
            end
          end else if (!last_sfx) begin
            sfx_d = sfx_cnt + 3'd1;
          end else begin
            in_sfx_d = 1'b0;
            sfx_d    = '0;
            if (field == FIELD_SCORE) begin
              state_d = ST_DONE;
            end else begin
              field_d  = nf;
              lz_d     = 1'b1;
              load     = 1'b1;
              load_val = (nf == FIELD_SCORE) ? score_q
                                             : SCORE_W'(board_q[CELL_W*nf[3:0] +: CELL_W]);
              state_d  = ST_CONV;
            end
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_board_uart_printer.sv
// Bench for board_uart_printer: frames are captured byte by byte and compared
// with a reference frame built from the board/score using decimal arithmetic.
module tb_board_uart_printer;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [319:0] board = '0;
  logic [20:0]  score = '0;
  logic         busy, done;

  board_uart_printer_if tx_if();

  board_uart_printer #(.CELL_W(20), .SCORE_W(21), .DIGITS(7)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .board (board),
    .score (score),
    .tx    (tx_if),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int rdy_mode = 0;
  int done_cnt = 0;
  int busy_at_done = 0;
  int stall_viol = 0;
  bit prev_stall = 0;
  logic [7:0] prev_char = '0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  // tx_ready changes just after the rising edge; 30% high in random mode.
  always @(posedge clk) begin
    #1;
    tx_if.tx_ready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 30);
  end

  // Capture accepted bytes and stall behaviour midway through each cycle.
  always @(negedge clk) begin
    if (tx_if.char_valid && tx_if.tx_ready) got_q.push_back(tx_if.char_out);
    if (done) begin
      done_cnt++;
      if (busy) busy_at_done++;
    end
    if (prev_stall && (!tx_if.char_valid || tx_if.char_out !== prev_char)) stall_viol++;
    prev_stall = tx_if.char_valid && !tx_if.tx_ready;
    prev_char  = tx_if.char_out;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  task automatic push_field(input int unsigned v, input bit is_cell);
    logic [7:0] c [7];
    int unsigned t;
    t = v;
    exp_q.push_back(8'h20);
    for (int i = 6; i >= 0; i--) begin
      if (t != 0 || i == 6) c[i] = 8'h30 + 8'(t % 10);
      else                  c[i] = 8'h20;
      t = t / 10;
    end
    if (v == 0 && is_cell) c[6] = 8'h2E;
    for (int i = 0; i < 7; i++) exp_q.push_back(c[i]);
  endtask

  task automatic build_exp(input logic [319:0] b, input logic [20:0] s);
    string sc;
    sc = "SCORE";
    exp_q.delete();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) push_field(int'(b[20*(4*r+c) +: 20]), 1'b1);
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
    for (int i = 0; i < 5; i++) exp_q.push_back(sc[i]);
    push_field(int'(s), 1'b0);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  function automatic int first_diff();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= got_q.size()) return i;
      if (got_q[i] !== exp_q[i]) return i;
    end
    if (got_q.size() != exp_q.size()) return exp_q.size();
    return -1;
  endfunction

  function automatic logic [7:0] got_at(input int i);
    return (i >= 0 && i < got_q.size()) ? got_q[i] : 8'hxx;
  endfunction

  function automatic logic [319:0] rand_board();
    logic [319:0] b;
    int unsigned r;
    for (int i = 0; i < 16; i++) begin
      r = $urandom_range(0, 18);
      if (r == 0)       b[20*i +: 20] = '0;
      else if (r == 18) b[20*i +: 20] = 20'($urandom);
      else              b[20*i +: 20] = 20'(1) << r;
    end
    return b;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic start_frame(input logic [319:0] b, input logic [20:0] s);
    @(negedge clk);
    got_q.delete();
    done_cnt = 0;
    busy_at_done = 0;
    stall_viol = 0;
    board = b;
    score = s;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int cyc;
    cyc = 0;
    while (done_cnt == 0 && cyc < 6000) begin
      @(posedge clk);
      cyc++;
    end
    ok = (done_cnt != 0);
    repeat (3) @(posedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++; if (tx_if.char_valid !== 1'b0) begin errors++; $display("FAIL reset_char_valid got=%b exp=0", tx_if.char_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (tx_if.char_out !== 8'h00) begin errors++; $display("FAIL reset_char_out got=%h exp=00", tx_if.char_out); end
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_zero_frame();
    bit ok;
    int d;
    rdy_mode = 0;
    build_exp('0, '0);
    start_frame('0, '0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy_rise got=%b exp=1", busy); end
    repeat (20) @(posedge clk);
    #1;
    checks++; if (tx_if.char_valid !== 1'b0) begin errors++; $display("FAIL zero_early_valid got=%b exp=0", tx_if.char_valid); end
    @(posedge clk);
    #1;
    checks++; if (tx_if.char_valid !== 1'b1) begin errors++; $display("FAIL zero_first_valid got=%b exp=1", tx_if.char_valid); end
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL zero_done_timeout got=0 exp=1"); end
    checks++; if (got_q.size() != 151) begin errors++; $display("FAIL zero_len got=%0d exp=151", got_q.size()); end
    d = first_diff();
    checks++; if (d >= 0) begin errors++; $display("FAIL zero_data byte=%0d got=%h exp=%h", d, got_at(d), (d < exp_q.size()) ? exp_q[d] : 8'hxx); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL zero_done_count got=%0d exp=1", done_cnt); end
    checks++; if (busy_at_done != 0) begin errors++; $display("FAIL zero_busy_at_done got=%0d exp=0", busy_at_done); end
  endtask

  task automatic test_values();
    bit ok, bad;
    int d;
    logic [319:0] b;
    string w1, w2, w3;
    w1 = "    2048"; w2 = "  131072"; w3 = "SCORE 1234567";
    b = '0;
    b[20*5 +: 20]  = 20'd2048;
    b[20*15 +: 20] = 20'd131072;
    build_exp(b, 21'd1234567);
    start_frame(b, 21'd1234567);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL values_done_timeout got=0 exp=1"); end
    d = first_diff();
    checks++; if (d >= 0) begin errors++; $display("FAIL values_data byte=%0d got=%h exp=%h", d, got_at(d), (d < exp_q.size()) ? exp_q[d] : 8'hxx); end
    bad = 0;
    for (int i = 0; i < 8; i++) if (got_at(42 + i) !== w1[i]) bad = 1;
    for (int i = 0; i < 8; i++) if (got_at(126 + i) !== w2[i]) bad = 1;
    for (int i = 0; i < 13; i++) if (got_at(136 + i) !== w3[i]) bad = 1;
    checks++; if (bad) begin errors++; $display("FAIL values_literal got=%h%h%h%h exp=2048 field at byte 42", got_at(46), got_at(47), got_at(48), got_at(49)); end
  endtask

  task automatic test_max();
    bit ok, bad;
    int d;
    logic [319:0] b;
    string w1, w2;
    w1 = " 1048575"; w2 = " 2097151";
    b = '1;
    build_exp(b, 21'h1FFFFF);
    start_frame(b, 21'h1FFFFF);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL max_done_timeout got=0 exp=1"); end
    d = first_diff();
    checks++; if (d >= 0) begin errors++; $display("FAIL max_data byte=%0d got=%h exp=%h", d, got_at(d), (d < exp_q.size()) ? exp_q[d] : 8'hxx); end
    bad = 0;
    for (int i = 0; i < 8; i++) if (got_at(i) !== w1[i] || got_at(141 + i) !== w2[i]) bad = 1;
    checks++; if (bad) begin errors++; $display("FAIL max_literal got=%h..%h exp=' 1048575'/' 2097151'", got_at(1), got_at(148)); end
  endtask

  task automatic test_stall();
    bit ok;
    int d;
    logic [319:0] b;
    logic [20:0] s;
    logic [7:0] ref_q[$];
    for (int n = 0; n < 2; n++) begin
      b = rand_board();
      s = 21'($urandom_range(0, 2097151));
      build_exp(b, s);
      rdy_mode = 0;
      start_frame(b, s);
      wait_done(ok);
      ref_q = got_q;
      rdy_mode = 1;
      start_frame(b, s);
      wait_done(ok);
      rdy_mode = 0;
      checks++; if (!ok) begin errors++; $display("FAIL stall_done_timeout got=0 exp=1"); end
      d = first_diff();
      checks++; if (d >= 0) begin errors++; $display("FAIL stall_data byte=%0d got=%h exp=%h", d, got_at(d), (d < exp_q.size()) ? exp_q[d] : 8'hxx); end
      checks++; if (got_q != ref_q) begin errors++; $display("FAIL stall_vs_ready len got=%0d exp=%0d", got_q.size(), ref_q.size()); end
      checks++; if (stall_viol != 0) begin errors++; $display("FAIL stall_stability got=%0d exp=0", stall_viol); end
    end
  endtask

  task automatic test_midframe();
    bit ok;
    int d, cyc;
    logic [319:0] b;
    logic [20:0] s;
    b = rand_board();
    s = 21'($urandom_range(0, 2097151));
    build_exp(b, s);
    start_frame(b, s);
    cyc = 0;
    while (got_q.size() < 50 && cyc < 3000) begin @(posedge clk); cyc++; end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      board = rand_board();
      score = 21'($urandom);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat ($urandom_range(5, 40)) @(posedge clk);
    end
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_done_timeout got=0 exp=1"); end
    d = first_diff();
    checks++; if (d >= 0) begin errors++; $display("FAIL mid_data byte=%0d got=%h exp=%h", d, got_at(d), (d < exp_q.size()) ? exp_q[d] : 8'hxx); end
    repeat (60) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || got_q.size() != 151) begin errors++; $display("FAIL mid_no_requeue busy=%b bytes=%0d exp busy=0 bytes=151", busy, got_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int d, cyc;
    logic [319:0] b;
    logic [20:0] s;
    b = rand_board();
    s = 21'($urandom_range(0, 2097151));
    start_frame(b, s);
    cyc = 0;
    while (got_q.size() < 40 && cyc < 3000) begin @(negedge clk); cyc++; end
    #2 rst = 1'b0;
    #1;
    checks++; if (tx_if.char_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_abort valid=%b busy=%b exp 0/0", tx_if.char_valid, busy); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || tx_if.char_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_restart busy=%b valid=%b exp 0/0", busy, tx_if.char_valid); end
    b = rand_board();
    s = 21'($urandom_range(0, 2097151));
    build_exp(b, s);
    start_frame(b, s);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_done_timeout got=0 exp=1"); end
    d = first_diff();
    checks++; if (d >= 0) begin errors++; $display("FAIL rstmid_data byte=%0d got=%h exp=%h", d, got_at(d), (d < exp_q.size()) ? exp_q[d] : 8'hxx); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int d, cyc;
    logic [319:0] b;
    logic [20:0] s;
    b = rand_board();
    s = 21'($urandom_range(0, 2097151));
    build_exp(b, s);
    start_frame(b, s);
    start = 1'b1;
    wait_done(ok);
    got_q.delete();
    done_cnt = 0;
    cyc = 0;
    while (!busy && cyc < 10) begin @(posedge clk); #1; cyc++; end
    @(negedge clk) start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart got=%b exp=1", busy); end
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_done_timeout got=0 exp=1"); end
    d = first_diff();
    checks++; if (d >= 0) begin errors++; $display("FAIL b2b_data byte=%0d got=%h exp=%h", d, got_at(d), (d < exp_q.size()) ? exp_q[d] : 8'hxx); end
  endtask

  initial begin
    test_reset();
    test_zero_frame();
    test_values();
    test_max();
    test_stall();
    test_midframe();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/board_uart_printer.md
# board_uart_printer

Serializes a snapshot of the 4x4 game board and score into a fixed-format ASCII frame, one byte at a time, for the UART transmitter. It sits between gameController (source of `board`/`score`) and uart_top (consumer of `char_out`). A `start` pulse triggers each frame. Decimal conversion uses a sequential shift-add-3 converter, which keeps the block small.

## Interface
Parameters:
- CELL_W, 20, bits per board cell (binary tile value, 0 = empty)
- SCORE_W, 21, score width
- DIGITS, 7, decimal field width

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  frame request, level-sampled; acted on only in IDLE
- board  in  320  cell i = board[20*i+19 : 20*i], i = 4*row+col, cell 0 top-left
- score  in  21  binary score
- tx_ready  in  1  UART can accept a byte (driven from ~uart_tx_busy)
- char_out  out  8  ASCII byte
- char_valid  out  1  char_out valid
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the last byte is accepted

## Operation
- Frame content, 151 bytes:
  - 4 rows, each made of 4 fields followed by CR (0x0D) and LF (0x0A).
  - Field = one space + 7-char right-justified decimal.
  - Leading zeros are printed as spaces. An empty cell prints six spaces then '.'.
  - Then "SCORE" (5 bytes), the score as a 7-char field (leading zeros as spaces, value 0 prints "      0"), then CR LF.
  - Per-row bytes: 4×8 + 2 = 34. Total: 136 + 5 + 8 + 2 = 151.
- FSM: IDLE, CONV, EMIT, DONE.
  - IDLE: when start=1, register board and score, set field=0, go to CONV.
  - CONV: the converter runs for exactly 21 cycles (SCORE_W shifts; cell values are zero-extended), then go to EMIT.
  - EMIT: present the current byte with char_valid=1. A byte transfers on a cycle where char_valid & tx_ready. After the field's 8th byte:
    - fields 3, 7, 11, 15 also emit CR LF;
    - field 15 emits "SCORE" after its CR LF;
    - otherwise field++ and return to CONV;
    - after the score field's LF, go to DONE.
  - DONE: pulse done for one cycle, then return to IDLE.
- char_out and char_valid are stable while char_valid=1 and tx_ready=0. No byte is ever dropped or repeated.
- Inputs are snapshotted at frame start. Changes to board or score mid-frame have no effect.
- start while busy is ignored and not queued. If start is still high on return to IDLE, a new frame begins.

## Timing
- Reset values:
  - state IDLE
  - char_out 8'h00
  - char_valid 0
  - busy 0
  - done 0
  - all counters 0
- Start sampled on edge k: busy=1 from k+1. First char_valid=1 at k+22 (1 snapshot cycle + 21 CONV cycles).
- With tx_ready held at 1: one byte per cycle within a field, plus a 21-cycle CONV gap between fields.
- busy falls in the same cycle done pulses.
- Reset asserted mid-frame: immediate abort. Outputs go to reset values asynchronously. A new start is required afterwards.
- tx_ready=1 while char_valid=0 has no effect.

## Structure
- Package twentyfortyeight_pkg holds:
  - CELL_W, NUM_CELLS=16, SCORE_W, DIGITS, FRAME_LEN=151
  - ASCII constants: SP, DOT, CR, LF, '0', and the "SCORE" bytes
  - state enum
- Sub-module bin2bcd_seq:
  - load/valid handshake
  - 21-bit in, 7×4-bit BCD out, 21-cycle latency
  - reused by later display stages
- The top-level FSM holds:
  - field counter 0..16
  - byte-in-field counter 0..7
  - suffix counter for CR/LF/"SCORE"
  - leading-zero flag

## Test plan
- All-zero board, score 0, tx_ready=1 → exactly 151 bytes. Each row is "      ." ×4 (each field prefixed by a space) then 0D 0A. Last line is "SCORE      0" 0D 0A. One done pulse.
- Cell 5 = 2048, cell 15 = 131072, score 1234567 → row 1 field 1 is "    2048". Row 3 field 3 is "  131072". Score line is "SCORE 1234567".
- Max values: all cells 20'hFFFFF, score 21'h1FFFFF → fields " 1048575" and score " 2097151". No overflow or truncation.
- tx_ready toggled by a random 30% duty pattern → the byte stream is identical to the tx_ready=1 run, and char_out is stable during stalls.
- start re-pulsed mid-frame and board changed mid-frame → one frame only, with content from the original snapshot.
- rst asserted after byte 40 → char_valid=0 and busy=0 immediately. A subsequent start produces a full 151-byte frame from byte 0.
